// File: rtl/opb_reg_pkg.sv
// Shared types and helpers for OPB software-register blocks.
package opb_reg_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACK  = 2'd1,
        WAIT = 2'd2
    } ack_state_e;

    localparam logic REG_DATA  = 1'b0;
    localparam logic REG_WRCNT = 1'b1;

    // be[3] is OPB_BE[0], which covers the most significant byte of the word.
    function automatic logic [31:0] be_merge(input logic [31:0] cur,
                                             input logic [31:0] wdata,
                                             input logic [3:0]  be);
        logic [31:0] r;
        r = cur;
        for (int i = 0; i < 4; i++)
            if (be[i]) r[8*i +: 8] = wdata[8*i +: 8];
        return r;
    endfunction

endpackage

// File: rtl/opb_slave_ack_fsm.sv
// Single-beat OPB slave handshake: one accept pulse and one xferAck per select,
// held off until the master drops select.
module opb_slave_ack_fsm
    import opb_reg_pkg::*;
(
    input  logic gclk,
    input  logic grst_n,
    input  logic select,
    input  logic hit,
    output logic accept,
    output logic xfer_ack
);

    ack_state_e state_q, state_d;

    always_ff @(posedge gclk or negedge grst_n) begin
        if (!grst_n) state_q <= IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        case (state_q)
            IDLE: if (select && hit) begin
                accept  = 1'b1;
                state_d = ACK;
            end
            ACK:  state_d = WAIT;
            // Master may keep select up after ack; do not re-acknowledge it.
            WAIT: if (!select) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign xfer_ack = (state_q == ACK);

endmodule

// File: rtl/opb_register_ppc2user.sv
// PPC-writable OPB register driven into user logic, with readback and update strobe.
// Optional OPB_REG_WRCNT_EN: read-only write counter at word offset 1.
module opb_register_ppc2user
    import opb_reg_pkg::*;
#(
    parameter logic [31:0] C_BASEADDR   = 32'h01008500,
    parameter logic [31:0] C_HIGHADDR   = 32'h010085FF,
    parameter int          C_OPB_AWIDTH = 32,
    parameter int          C_OPB_DWIDTH = 32,
    parameter logic [31:0] C_INIT_VALUE = 32'h00000000
) (
    input  logic                    OPB_Clk,
    input  logic                    OPB_Rst_n,
    input  logic [0:C_OPB_AWIDTH-1] OPB_ABus,
    input  logic [0:3]              OPB_BE,
    input  logic [0:C_OPB_DWIDTH-1] OPB_DBus,
    input  logic                    OPB_RNW,
    input  logic                    OPB_select,
    input  logic                    OPB_seqAddr,
    output logic [0:C_OPB_DWIDTH-1] Sl_DBus,
    output logic                    Sl_xferAck,
    output logic                    Sl_errAck,
    output logic                    Sl_retry,
    output logic                    Sl_toutSup,
    output logic [31:0]             user_data_out,
    output logic                    user_data_valid
);

    // Declared MSB-first, so OPB bit 0 lands on user bit 31.
    logic [31:0] addr, wdata;
    logic [3:0]  be;
    logic        hit, offset, accept, xfer_ack;
    logic        wr_data, wr_upd;
    logic [31:0] data_q, rd_word, rd_q;
    logic        valid_q;
    logic        unused_seq;

    assign addr       = OPB_ABus;
    assign wdata      = OPB_DBus;
    assign be         = OPB_BE;
    assign unused_seq = OPB_seqAddr;

    assign hit    = (addr >= C_BASEADDR) && (addr <= C_HIGHADDR);
    assign offset = OPB_ABus[29];

    opb_slave_ack_fsm u_ack (
        .gclk     (OPB_Clk),
        .grst_n   (OPB_Rst_n),
        .select   (OPB_select),
        .hit      (hit),
        .accept   (accept),
        .xfer_ack (xfer_ack)
    );

`ifdef OPB_REG_WRCNT_EN
    logic [31:0] wrcnt_q;

    assign wr_data = accept && !OPB_RNW && (offset == REG_DATA);
    assign rd_word = (offset == REG_WRCNT) ? wrcnt_q : data_q;

    always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
        if (!OPB_Rst_n)  wrcnt_q <= '0;
        else if (wr_upd) wrcnt_q <= wrcnt_q + 32'd1;
    end
`else
    // Without the counter, offset 1 is an alias of the data register.
    assign wr_data = accept && !OPB_RNW;
    assign rd_word = data_q;
`endif

    assign wr_upd = wr_data && (|be);

    always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
        if (!OPB_Rst_n) begin
            data_q  <= C_INIT_VALUE;
            valid_q <= 1'b0;
            rd_q    <= '0;
        end else begin
            if (wr_upd) data_q <= be_merge(data_q, wdata, be);
            valid_q <= wr_upd;
            rd_q    <= (accept && OPB_RNW) ? rd_word : '0;
        end
    end

    // Wired-OR bus: drive zero outside the acknowledge cycle.
    assign Sl_DBus         = xfer_ack ? rd_q : '0;
    assign Sl_xferAck      = xfer_ack;
    assign Sl_errAck       = 1'b0;
    assign Sl_retry        = 1'b0;
    assign Sl_toutSup      = 1'b0;
    assign user_data_out   = data_q;
    assign user_data_valid = valid_q;

endmodule

// File: tb/tb_opb_register_ppc2user.sv
// Self-checking bench for opb_register_ppc2user: vector table, corner sequences, random vs model.
module tb_opb_register_ppc2user;

    localparam logic [31:0] BASE = 32'h01008500;
    localparam logic [31:0] HIGH = 32'h010085FF;
    localparam logic [31:0] INIT = 32'hA5A50001;
`ifdef OPB_REG_WRCNT_EN
    localparam bit WRCNT = 1'b1;
`else
    localparam bit WRCNT = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [0:31] abus = '0;
    logic [0:3]  be = '0;
    logic [0:31] dbus = '0;
    logic        rnw = 1'b0, sel = 1'b0, seq = 1'b0;
    logic [0:31] Sl_DBus;
    logic        Sl_xferAck, Sl_errAck, Sl_retry, Sl_toutSup;
    logic [31:0] user_data_out;
    logic        user_data_valid;

    int checks = 0;
    int failures = 0;

    logic [31:0] m_reg, m_cnt;

    always #5 clk = ~clk;

    opb_register_ppc2user #(.C_INIT_VALUE(INIT)) dut (
        .OPB_Clk(clk), .OPB_Rst_n(rst_n), .OPB_ABus(abus), .OPB_BE(be),
        .OPB_DBus(dbus), .OPB_RNW(rnw), .OPB_select(sel), .OPB_seqAddr(seq),
        .Sl_DBus(Sl_DBus), .Sl_xferAck(Sl_xferAck), .Sl_errAck(Sl_errAck),
        .Sl_retry(Sl_retry), .Sl_toutSup(Sl_toutSup),
        .user_data_out(user_data_out), .user_data_valid(user_data_valid)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // One OPB transfer. Select released 'hold' cycles after ack (or after timeout),
    // then 'post' more cycles are watched for stray ack/valid/data.
    task automatic xfer(input logic [31:0] a, input bit r, input logic [0:3] b,
                        input logic [31:0] d, input int hold, input int post,
                        output bit acked, output logic [31:0] rd, output logic [31:0] udo,
                        output int nack, output int nval, output int viol, output int lat);
        int rel;
        acked = 0; rd = '0; udo = '0; nack = 0; nval = 0; viol = 0; lat = -1; rel = 7;
        @(negedge clk);
        abus = a; rnw = r; be = b; dbus = d; sel = 1'b1;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (Sl_xferAck) begin
                nack++;
                if (!acked) begin
                    acked = 1; rd = Sl_DBus; udo = user_data_out; lat = c; rel = c + hold;
                end
            end else if (Sl_DBus !== '0) viol++;
            if (user_data_valid) nval++;
            if (c >= rel) break;
        end
        sel = 1'b0;
        if (!acked) udo = user_data_out;
        for (int c = 0; c < post; c++) begin
            @(negedge clk);
            if (Sl_xferAck) nack++;
            else if (Sl_DBus !== '0) viol++;
            if (user_data_valid) nval++;
        end
    endtask

    task automatic run(input string nm, input logic [31:0] a, input bit r, input logic [0:3] b,
                       input logic [31:0] d, input bit e_ack, input logic [31:0] e_rd,
                       input logic [31:0] e_udo, input int e_val);
        bit acked; logic [31:0] rd, udo; int nack, nval, viol, lat;
        xfer(a, r, b, d, 0, 2, acked, rd, udo, nack, nval, viol, lat);
        chk({nm, "_nack"}, nack, e_ack ? 1 : 0);
        if (acked) chk({nm, "_lat"}, lat, 0);
        chk({nm, "_rd"}, rd, e_rd);
        chk({nm, "_udo"}, udo, e_udo);
        chk({nm, "_valid"}, nval, e_val);
        chk({nm, "_dbus0"}, viol, 0);
    endtask

    // Reference: byte k of the OPB word is user bits [31-8k -: 8], enabled by be[k].
    function automatic logic [31:0] model_merge(logic [31:0] cur, logic [31:0] d, logic [0:3] b);
        logic [31:0] r;
        r = cur;
        for (int k = 0; k < 4; k++)
            if (b[k]) r[31-8*k -: 8] = d[31-8*k -: 8];
        return r;
    endfunction

    typedef struct {
        logic [31:0] a;
        bit          r;
        logic [0:3]  b;
        logic [31:0] d;
        bit          ack;
        logic [31:0] rd;
        logic [31:0] udo;
        int          val;
    } vec_t;

    vec_t tbl[10];

    initial begin
        bit acked; logic [31:0] rd, udo; int nack, nval, viol, lat;

        tbl[0] = '{BASE,        1, 4'b1111, 32'h0,        1, INIT,         INIT,         0};
        tbl[1] = '{BASE,        0, 4'b1111, 32'hDEADBEEF, 1, 32'h0,        32'hDEADBEEF, 1};
        tbl[2] = '{BASE + 16,   1, 4'b0000, 32'h0,        1, 32'hDEADBEEF, 32'hDEADBEEF, 0};
        tbl[3] = '{BASE,        0, 4'b0100, 32'h11223344, 1, 32'h0,        32'hDE22BEEF, 1};
        tbl[4] = '{BASE,        0, 4'b0000, 32'h12345678, 1, 32'h0,        32'hDE22BEEF, 0};
        tbl[5] = '{HIGH + 1,    1, 4'b1111, 32'h0,        0, 32'h0,        32'hDE22BEEF, 0};
        tbl[6] = '{BASE - 4,    0, 4'b1111, 32'hFFFFFFFF, 0, 32'h0,        32'hDE22BEEF, 0};
        tbl[7] = '{BASE + 4,    1, 4'b1111, 32'h0,        1, WRCNT ? 32'd2 : 32'hDE22BEEF, 32'hDE22BEEF, 0};
        tbl[8] = '{BASE + 4,    0, 4'b1111, 32'hCAFEF00D, 1, 32'h0,
                   WRCNT ? 32'hDE22BEEF : 32'hCAFEF00D, WRCNT ? 0 : 1};
        tbl[9] = '{HIGH,        1, 4'b0000, 32'h0,        1, WRCNT ? 32'd2 : 32'hCAFEF00D,
                   WRCNT ? 32'hDE22BEEF : 32'hCAFEF00D, 0};

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_ack", Sl_xferAck, 0);
        chk("rst_dbus", Sl_DBus, 0);
        chk("rst_udo", user_data_out, INIT);
        chk("rst_valid", user_data_valid, 0);
        chk("rst_const", {Sl_errAck, Sl_retry, Sl_toutSup}, 0);
        rst_n = 1'b1;

        foreach (tbl[i])
            run($sformatf("vec%0d", i), tbl[i].a, tbl[i].r, tbl[i].b, tbl[i].d,
                tbl[i].ack, tbl[i].rd, tbl[i].udo, tbl[i].val);
        m_reg = WRCNT ? 32'hDE22BEEF : 32'hCAFEF00D;
        m_cnt = 32'd2;

        // Select held 3 cycles past ack, then re-selected after one idle cycle
        xfer(BASE, 0, 4'b1111, 32'h0F0F0F0F, 3, 0, acked, rd, udo, nack, nval, viol, lat);
        chk("hold_nack", nack, 1);
        chk("hold_valid", nval, 1);
        chk("hold_udo", udo, 32'h0F0F0F0F);
        m_reg = 32'h0F0F0F0F; m_cnt++;
        run("reaccept", BASE, 1, 4'b0000, 32'h0, 1, 32'h0F0F0F0F, 32'h0F0F0F0F, 0);

        // Randomized transfers against the model
        for (int n = 0; n < 60; n++) begin
            logic [31:0] a, d, e_rd, e_udo;
            logic [0:3]  b;
            bit          r, h, e_ack;
            int          e_val;
            case ($urandom_range(0, 7))
                0:       a = HIGH + 1 + $urandom_range(0, 255);
                1:       a = BASE - 1 - $urandom_range(0, 255);
                default: a = BASE + $urandom_range(0, 255);
            endcase
            r = $urandom_range(0, 1);
            b = 4'($urandom_range(0, 15));
            d = $urandom;
            h = (a >= BASE) && (a <= HIGH);
            e_ack = h; e_rd = '0; e_val = 0;
            if (h && r) e_rd = (WRCNT && a[2]) ? m_cnt : m_reg;
            if (h && !r && !(WRCNT && a[2]) && (b != 4'b0000)) begin
                m_reg = model_merge(m_reg, d, b);
                m_cnt++;
                e_val = 1;
            end
            e_udo = m_reg;
            run($sformatf("rnd%0d", n), a, r, b, d, e_ack, e_rd, e_udo, e_val);
        end

        // Reset during the acknowledge cycle
        @(negedge clk);
        abus = BASE; rnw = 0; be = 4'b1111; dbus = 32'h55AA55AA; sel = 1'b1;
        @(negedge clk);
        chk("rstack_pre", Sl_xferAck, 1);
        #1 rst_n = 1'b0;
        #1;
        chk("rstack_ack", Sl_xferAck, 0);
        chk("rstack_udo", user_data_out, INIT);
        chk("rstack_valid", user_data_valid, 0);
        sel = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        m_reg = INIT; m_cnt = 0;
        run("post_rst_rd", BASE, 1, 4'b1111, 32'h0, 1, INIT, INIT, 0);

`ifdef OPB_REG_WRCNT_EN
        run("cnt_w1", BASE, 0, 4'b1111, 32'h1, 1, 0, 32'h1, 1);
        run("cnt_w2", BASE, 0, 4'b0001, 32'h2, 1, 0, 32'h2, 1);
        run("cnt_w3", BASE, 0, 4'b1000, 32'h03000000, 1, 0, 32'h03000002, 1);
        run("cnt_rd3", BASE + 4, 1, 4'b1111, 0, 1, 32'd3, 32'h03000002, 0);
        run("cnt_wro", BASE + 4, 0, 4'b1111, 32'hFFFF, 1, 0, 32'h03000002, 0);
        run("cnt_rd3b", BASE + 4, 1, 4'b1111, 0, 1, 32'd3, 32'h03000002, 0);
        @(negedge clk);
        force dut.wrcnt_q = 32'hFFFFFFFF;
        #1 release dut.wrcnt_q;
        run("cnt_wrapw", BASE, 0, 4'b1111, 32'h77, 1, 0, 32'h77, 1);
        run("cnt_wrap", BASE + 4, 1, 4'b1111, 0, 1, 32'd0, 32'h77, 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
